// File: rtl/imem_pkg.sv
// Shared constants and types for the pipelined instruction memory.
// Fault reasons are defined here ahead of the planned debug ports.
package imem_pkg;

  localparam logic [31:0] NOP_WORD    = 32'hD503201F;
  localparam int          LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_MISALIGNED   = 2'd1,
    FAULT_OUT_OF_RANGE = 2'd2
  } fault_reason_e;

endpackage

// File: rtl/imem_stage.sv
// One read-pipeline stage: a {valid, data, fault} register that holds while en is low.
module imem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_fault,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fault
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fault_q, fault_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fault_d = fault_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = in_data;
      fault_d = in_fault;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_fault = fault_q;

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Stallable LATENCY-stage instruction memory with a word-load port,
// alignment/range fault detection and fetch/fault statistics.
module instruction_memory_pipelined
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_index,
  input  logic [DATA_W-1:0] ld_data,
  output logic [31:0]       fetch_count,
  output logic [15:0]       fault_count
);

  // Out-of-range LATENCY values are clamped rather than producing an empty pipeline.
  localparam int STAGES = (LATENCY < 1) ? 1 :
                          (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              stall, advance, accept;
  logic              misaligned, out_of_range, req_fault;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;

  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_fault;
  logic [DATA_W-1:0] stg_data [STAGES];

  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] fault_count_q, fault_count_d;

  always_comb begin
    misaligned   = (req_addr[1:0] != 2'b00);
    out_of_range = ((req_addr >> 2) >= ADDR_W'(DEPTH));
    req_fault    = misaligned | out_of_range;
    rd_index     = req_addr[IDX_W+1:2];
    stall        = stg_valid[STAGES-1] & ~rsp_ready;
    advance      = ~stall;
    accept       = req_valid & advance;
    // Bubbles and faults carry zero data so nothing undefined enters the pipe.
    rd_data      = (accept & ~req_fault) ? mem_q[rd_index] : '0;
  end

  // Loads ignore stall; the read above sees the pre-edge word.
  always_ff @(posedge CLK) begin
    if (ld_en) begin
      mem_q[ld_index] <= ld_data;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      imem_stage #(.DATA_W(DATA_W)) u_stage (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .en        (advance),
        .in_valid  (accept),
        .in_data   (rd_data),
        .in_fault  (accept & req_fault),
        .out_valid (stg_valid[i]),
        .out_data  (stg_data[i]),
        .out_fault (stg_fault[i])
      );
    end else begin : g_next
      imem_stage #(.DATA_W(DATA_W)) u_stage (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .en        (advance),
        .in_valid  (stg_valid[i-1]),
        .in_data   (stg_data[i-1]),
        .in_fault  (stg_fault[i-1]),
        .out_valid (stg_valid[i]),
        .out_data  (stg_data[i]),
        .out_fault (stg_fault[i])
      );
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    fault_count_d = fault_count_q;
    if (accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
      if (req_fault && (fault_count_q != 16'hFFFF)) begin
        fault_count_d = fault_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetch_count_q <= '0;
      fault_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign req_ready   = advance;
  assign rsp_valid   = stg_valid[STAGES-1];
  assign rsp_data    = stg_data[STAGES-1];
  assign rsp_fault   = stg_fault[STAGES-1];
  assign fetch_count = fetch_count_q;
  assign fault_count = fault_count_q;

endmodule
